// File: rtl/rc4_pkg.sv
// rc4_pkg: shared definitions for the RC4 decrypt stage and the key-search
// controller.
//   rc4_state_e     - decryptor FSM states
//   MSG_LEN_DEFAULT - default message length in bytes
//   CHAR_*          - bounds of the accepted plaintext alphabet
//   is_plain_char   - 1 when a byte is a lowercase letter or a space
package rc4_pkg;

  localparam int MSG_LEN_DEFAULT = 32;

  localparam logic [7:0] CHAR_A     = 8'h61;
  localparam logic [7:0] CHAR_Z     = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [3:0] {
    IDLE,
    SI_REQ,
    SI_CAP,
    SJ_REQ,
    SJ_CAP,
    WR_I,
    WR_J,
    F_REQ,
    F_CAP,
    WR_D,
    DONE
  } rc4_state_e;

  function automatic logic is_plain_char(input logic [7:0] b);
    return ((b >= CHAR_A) && (b <= CHAR_Z)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/rc4_decrypt_msg_if.sv
// rc4_decrypt_msg_if: groups the control handshake, the ciphertext array and
// both RAM buses of the RC4 decrypt stage.
//   start/busy/done/valid      - handshake with the ROM reader / key search
//   enc_data                   - ciphertext bytes, held stable for a whole run
//   s_address/s_data/s_wren/s_q - 256x8 S RAM port (registered-address read)
//   d_address/d_data/d_wren    - 32x8 decrypted-message RAM write port
// Modports: master = decryptor side, slave = environment side.
interface rc4_decrypt_msg_if
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT,
  parameter int AW      = $clog2(MSG_LEN)
);

  logic                    start;
  logic [MSG_LEN-1:0][7:0] enc_data;
  logic                    busy;
  logic                    done;
  logic                    valid;

  logic [7:0]              s_address;
  logic [7:0]              s_data;
  logic                    s_wren;
  logic [7:0]              s_q;

  logic [AW-1:0]           d_address;
  logic [7:0]              d_data;
  logic                    d_wren;

  modport master (
    input  start, enc_data, s_q,
    output busy, done, valid,
    output s_address, s_data, s_wren,
    output d_address, d_data, d_wren
  );

  modport slave (
    output start, enc_data, s_q,
    input  busy, done, valid,
    input  s_address, s_data, s_wren,
    input  d_address, d_data, d_wren
  );

endinterface

// File: rtl/rc4_decrypt_msg.sv
// rc4_decrypt_msg: RC4 PRGA keystream generator and message decryptor.
// On start it walks the key-scheduled S RAM, one byte per 9 states, XORs each
// keystream byte with the matching ciphertext byte, writes the plaintext to
// the decrypted-message RAM and tracks whether every plaintext byte is a
// lowercase letter or a space.
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - rc4_decrypt_msg_if.master (handshake, ciphertext, S/D RAM buses)
// All bus outputs are decoded combinationally from the current state, so the
// RAM strobes are exactly one state wide and drop to 0 as soon as reset
// forces IDLE.
module rc4_decrypt_msg
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rc4_decrypt_msg_if.master    bus
);

  localparam int            AW     = $clog2(MSG_LEN);
  localparam logic [AW-1:0] LAST_K = AW'(MSG_LEN - 1);

  rc4_state_e    r_state;
  rc4_state_e    w_state_nxt;

  logic [7:0]    r_i;
  logic [7:0]    r_j;
  logic [7:0]    r_si;
  logic [7:0]    r_sj;
  logic [7:0]    r_f;
  logic [AW-1:0] r_k;
  logic          r_valid;

  logic [7:0]    w_plain;
  logic          w_start_ok;

  // enc_data is read directly here; the ROM reader holds it stable for the run.
  assign w_plain    = r_f ^ bus.enc_data[r_k];
  assign w_start_ok = bus.start && ((r_state == IDLE) || (r_state == DONE));

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_si    <= 8'd0;
      r_sj    <= 8'd0;
      r_f     <= 8'd0;
      r_k     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        // PRGA starts with i already pre-incremented from 0.
        r_i     <= 8'd1;
        r_j     <= 8'd0;
        r_k     <= '0;
        r_valid <= 1'b1;
      end else begin
        case (r_state)
          SI_CAP: begin
            r_si <= bus.s_q;
            r_j  <= r_j + bus.s_q;
          end
          SJ_CAP: r_sj <= bus.s_q;
          F_CAP:  r_f  <= bus.s_q;
          WR_D: begin
            if (!is_plain_char(w_plain)) r_valid <= 1'b0;
            if (r_k != LAST_K) begin
              r_k <= r_k + 1'b1;
              r_i <= r_i + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Next state and bus decode
  always_comb begin
    w_state_nxt   = r_state;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.valid     = 1'b0;
    bus.s_address = 8'd0;
    bus.s_data    = 8'd0;
    bus.s_wren    = 1'b0;
    bus.d_address = '0;
    bus.d_data    = 8'd0;
    bus.d_wren    = 1'b0;
    case (r_state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) w_state_nxt = SI_REQ;
      end
      SI_REQ: begin
        bus.s_address = r_i;
        w_state_nxt   = SI_CAP;
      end
      SI_CAP: w_state_nxt = SJ_REQ;
      SJ_REQ: begin
        bus.s_address = r_j;
        w_state_nxt   = SJ_CAP;
      end
      SJ_CAP: w_state_nxt = WR_I;
      // When i==j both writes hit one location and si lands last, which is
      // the correct result of swapping an entry with itself.
      WR_I: begin
        bus.s_address = r_i;
        bus.s_data    = r_sj;
        bus.s_wren    = 1'b1;
        w_state_nxt   = WR_J;
      end
      WR_J: begin
        bus.s_address = r_j;
        bus.s_data    = r_si;
        bus.s_wren    = 1'b1;
        w_state_nxt   = F_REQ;
      end
      F_REQ: begin
        bus.s_address = r_si + r_sj;
        w_state_nxt   = F_CAP;
      end
      F_CAP: w_state_nxt = WR_D;
      WR_D: begin
        bus.d_address = r_k;
        bus.d_data    = w_plain;
        bus.d_wren    = 1'b1;
        w_state_nxt   = (r_k == LAST_K) ? DONE : SI_REQ;
      end
      DONE: begin
        bus.busy  = 1'b0;
        bus.done  = 1'b1;
        bus.valid = r_valid;
        if (bus.start) w_state_nxt = SI_REQ;
      end
      default: begin
        bus.busy    = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_decrypt_msg.sv
// tb_rc4_decrypt_msg: directed + randomized bench for rc4_decrypt_msg with
// behavioural S/D RAMs and a plain RC4 PRGA reference model.
module tb_rc4_decrypt_msg;

  localparam int N = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rc4_decrypt_msg_if #(.MSG_LEN(N)) bus ();

  rc4_decrypt_msg #(.MSG_LEN(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural RAMs: registered address, unregistered read data.
  logic [7:0] mem_s [256];
  logic [7:0] mem_d [N];
  logic [7:0] s_addr_r = 8'd0;

  always @(posedge clk) begin
    if (bus.s_wren) mem_s[bus.s_address] <= bus.s_data;
    if (bus.d_wren) mem_d[bus.d_address] <= bus.d_data;
    s_addr_r <= bus.s_address;
  end
  assign bus.s_q = mem_s[s_addr_r];

  // Strobe monitors
  int sw_cnt, dw_cnt, dw_rise;
  logic dw_prev = 1'b0;
  always @(posedge clk) begin
    if (bus.s_wren) sw_cnt++;
    if (bus.d_wren) begin
      dw_cnt++;
      if (!dw_prev) dw_rise++;
    end
    dw_prev = bus.d_wren;
  end

  // Reference model state
  logic [7:0] ms [256];
  logic [7:0] ks [N];
  logic [7:0] s1_d [N];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Standard RC4 PRGA over the model S array; leaves ms in its post-run state.
  task automatic model_prga();
    int i = 0;
    int j = 0;
    logic [7:0] t;
    for (int k = 0; k < N; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(ms[i])) % 256;
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
      ks[k] = ms[(int'(ms[i]) + int'(ms[j])) % 256];
    end
  endtask

  // mode 0: identity, 1: all 0xFF, 2: random permutation
  task automatic load_s(input int mode);
    logic [7:0] p [256];
    logic [7:0] t;
    for (int x = 0; x < 256; x++) p[x] = (mode == 1) ? 8'hFF : 8'(x);
    if (mode == 2)
      for (int x = 255; x > 0; x--) begin
        int r;
        r = int'($urandom_range(x, 0));
        t = p[x]; p[x] = p[r]; p[r] = t;
      end
    @(negedge clk);
    for (int x = 0; x < 256; x++) begin
      ms[x]     = p[x];
      mem_s[x] <= p[x];
    end
    for (int d = 0; d < N; d++) mem_d[d] <= 8'hEE;
  endtask

  task automatic start_run(input bit hold);
    @(negedge clk);
    sw_cnt = 0; dw_cnt = 0; dw_rise = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // The start-sampling edge counts as edge 1.
  task automatic wait_done(output int edges, output bit busy_ok);
    edges = 1;
    busy_ok = 1'b1;
    while (!bus.done && edges < 400) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk);
      edges++;
      #1;
    end
  endtask

  task automatic check_timing(input string tag, input int edges, input bit busy_ok);
    chk({tag, " done_latency"}, edges, 289);
    chk({tag, " busy_during_run"}, busy_ok, 1);
    chk({tag, " s_wren_cycles"}, sw_cnt, 64);
    chk({tag, " d_wren_cycles"}, dw_cnt, 32);
    chk({tag, " d_wren_pulses"}, dw_rise, 32);
    chk({tag, " busy_at_done"}, bus.busy, 0);
  endtask

  task automatic check_result(input string tag);
    logic [7:0] p;
    bit ev = 1'b1;
    for (int k = 0; k < N; k++) begin
      p = ks[k] ^ bus.enc_data[k];
      chk($sformatf("%s d[%0d]", tag, k), mem_d[k], p);
      if (!(((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20))) ev = 1'b0;
    end
    chk({tag, " done"}, bus.done, 1);
    chk({tag, " valid"}, bus.valid, ev);
  endtask

  task automatic run_full(input string tag);
    int e;
    bit b;
    start_run(1'b0);
    wait_done(e, b);
    check_timing(tag, e, b);
    check_result(tag);
  endtask

  initial begin
    int e;
    bit b;
    reset_n = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < N; k++) bus.enc_data[k] = 8'h00;
    #12;
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst valid", bus.valid, 0);
    chk("rst s_wren", bus.s_wren, 0);
    chk("rst d_wren", bus.d_wren, 0);
    chk("rst s_address", bus.s_address, 0);
    chk("rst d_data", bus.d_data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Identity S, zero ciphertext: plaintext equals the keystream.
    load_s(0);
    model_prga();
    run_full("ident");
    chk("ident d0_const", mem_d[0], 8'h02);
    chk("ident d1_const", mem_d[1], 8'h05);
    chk("ident d2_const", mem_d[2], 8'h07);
    for (int x = 0; x < 256; x++) chk($sformatf("ident s[%0d]", x), mem_s[x], ms[x]);
    for (int k = 0; k < N; k++) s1_d[k] = mem_d[k];

    // Ciphertext chosen to decrypt to 'a' (space at byte 5).
    load_s(0);
    model_prga();
    for (int k = 0; k < N; k++) bus.enc_data[k] = ks[k] ^ ((k == 5) ? 8'h20 : 8'h61);
    run_full("alpha");
    chk("alpha valid_const", bus.valid, 1);
    chk("alpha d5_space", mem_d[5], 8'h20);
    chk("alpha d31_a", mem_d[31], 8'h61);

    // Last byte decrypts to 'A' -> rejected.
    load_s(0);
    model_prga();
    bus.enc_data[31] = ks[31] ^ 8'h41;
    run_full("upperA");
    chk("upperA valid_const", bus.valid, 0);

    // All 0xFF S: keystream is all 0xFF, j and F address wrap every byte.
    load_s(1);
    model_prga();
    for (int k = 0; k < N; k++) bus.enc_data[k] = 8'($urandom);
    run_full("allff");
    for (int k = 0; k < N; k++)
      chk($sformatf("allff xor[%0d]", k), mem_d[k], 8'hFF ^ bus.enc_data[k]);

    // Random permutations with random ciphertext.
    for (int r = 0; r < 2; r++) begin
      load_s(2);
      model_prga();
      for (int k = 0; k < N; k++) bus.enc_data[k] = 8'($urandom);
      run_full($sformatf("rand%0d", r));
      for (int x = 0; x < 256; x++) chk($sformatf("rand%0d s[%0d]", r, x), mem_s[x], ms[x]);
    end

    // Asynchronous reset in the middle of byte 10.
    load_s(0);
    for (int k = 0; k < N; k++) bus.enc_data[k] = 8'h00;
    start_run(1'b0);
    e = 0;
    while (dw_cnt < 10 && e < 200) begin
      @(posedge clk);
      e++;
    end
    chk("midrst reached_byte10", (dw_cnt >= 10), 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst busy", bus.busy, 0);
    chk("midrst done", bus.done, 0);
    chk("midrst s_address", bus.s_address, 0);
    chk("midrst s_data", bus.s_data, 0);
    chk("midrst s_wren", bus.s_wren, 0);
    chk("midrst d_address", bus.d_address, 0);
    chk("midrst d_wren", bus.d_wren, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midrst idle_after", bus.busy, 0);
    load_s(0);
    model_prga();
    run_full("rerun");
    for (int k = 0; k < N; k++) chk($sformatf("rerun same[%0d]", k), mem_d[k], s1_d[k]);

    // start held high: no mid-run restart; DONE with start high restarts.
    load_s(2);
    model_prga();
    for (int k = 0; k < N; k++) bus.enc_data[k] = 8'($urandom);
    start_run(1'b1);
    wait_done(e, b);
    check_timing("hold", e, b);
    check_result("hold");
    @(posedge clk);
    #1;
    chk("restart done_cleared", bus.done, 0);
    chk("restart busy", bus.busy, 1);
    sw_cnt = 0; dw_cnt = 0; dw_rise = 0;
    bus.start = 1'b0;
    model_prga();
    for (int x = 0; x < 256; x++) mem_d[x % N] <= 8'hEE;
    wait_done(e, b);
    check_timing("restart", e, b);
    check_result("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
